// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter and burst sequencer for the shared 8-source 32-bit bus.
// Owns the bus mux select; hands ownership over back-to-back with no idle cycle.
module bus_arbiter_8 #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] last,
    input  logic       ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       bus_valid,
    output logic       xfer
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(MAX_BEATS - 1);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] beat_cnt;

    logic       release_now;
    logic [2:0] next_ptr;
    logic [2:0] pick_base;
    logic [2:0] next_owner;

    // First requester at or after base, wrapping modulo 8.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] result;
        logic [2:0] idx;
        logic       found;
        result = base;
        found  = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (!found && r[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    always_comb begin
        bus_valid   = (state == BUSY) && req[sel];
        xfer        = bus_valid && ready;
        release_now = (state == BUSY) &&
                      (!req[sel] || (xfer && (last[sel] || (beat_cnt == BEAT_LAST))));
        next_ptr    = sel + 3'd1;
        // On release the old owner drops to lowest priority for the same-cycle handoff.
        pick_base   = (state == BUSY) ? next_ptr : ptr;
        next_owner  = pick(req, pick_base);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        sel      <= next_owner;
                        grant    <= 8'd1 << next_owner;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        ptr <= next_ptr;
                        if (req != '0) begin
                            sel      <= next_owner;
                            grant    <= 8'd1 << next_owner;
                            beat_cnt <= '0;
                        end else begin
                            grant    <= '0;
                            state    <= IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Randomized and directed scoreboard bench for bus_arbiter_8 against a
// cycle-level reference model of the round-robin burst rules.
module tb_bus_arbiter_8;

    localparam int MB = 4;

    logic       clock;
    logic       reset;
    logic [7:0] req;
    logic [7:0] last;
    logic       ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       bus_valid;
    logic       xfer;

    bus_arbiter_8 #(.MAX_BEATS(MB)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .ready     (ready),
        .sel       (sel),
        .grant     (grant),
        .bus_valid (bus_valid),
        .xfer      (xfer)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       valid;
        logic       xfer;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: owner index (-1 when idle), priority pointer, words accepted.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_cnt;

    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 0; k < 8; k++) begin
            if (r[(base + k) % 8]) return (base + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
    endtask

    // Drive one cycle of inputs, record the expected outputs, then advance the model past the next edge.
    task automatic cycle(input logic [7:0] r, input logic [7:0] l, input logic rd, input logic rs);
        exp_t e;
        int   o;
        bit   v, x, done;
        @(posedge clock);
        #1;
        req   = r;
        last  = l;
        ready = rd;
        reset = rs;
        if (rs) begin
            model_reset();
            e.grant = 8'h00;
            e.sel   = 3'd0;
            e.valid = 1'b0;
            e.xfer  = 1'b0;
            sbq.push_back(e);
            return;
        end
        o = m_owner;
        v = (o >= 0) && r[m_sel];
        x = v && rd;
        e.grant = (o >= 0) ? 8'(1 << o) : 8'h00;
        e.sel   = 3'(m_sel);
        e.valid = v;
        e.xfer  = x;
        sbq.push_back(e);
        if (o < 0) begin
            if (r != 8'h00) begin
                m_owner = pick(r, m_ptr);
                m_sel   = m_owner;
                m_cnt   = 0;
            end
        end else begin
            done = !r[o] || (x && (l[o] || (m_cnt + 1 == MB)));
            if (done) begin
                m_ptr = (o + 1) % 8;
                if (r != 8'h00) begin
                    m_owner = pick(r, m_ptr);
                    m_sel   = m_owner;
                    m_cnt   = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (x) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks += 4;
            if (grant !== e.grant) begin
                failures++;
                $display("FAIL grant t=%0t got=%h exp=%h", $time, grant, e.grant);
            end
            if (sel !== e.sel) begin
                failures++;
                $display("FAIL sel t=%0t got=%0d exp=%0d", $time, sel, e.sel);
            end
            if (bus_valid !== e.valid) begin
                failures++;
                $display("FAIL bus_valid t=%0t got=%b exp=%b", $time, bus_valid, e.valid);
            end
            if (xfer !== e.xfer) begin
                failures++;
                $display("FAIL xfer t=%0t got=%b exp=%b", $time, xfer, e.xfer);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic [7:0] l;
        logic       rd;
        reset = 1'b1;
        req   = 8'h00;
        last  = 8'h00;
        ready = 1'b0;
        model_reset();
        repeat (2) cycle(8'h00, 8'h00, 1'b0, 1'b1);
        cycle(8'h00, 8'h00, 1'b0, 1'b0);

        // Single requester, three words ending on last.
        cycle(8'h04, 8'h00, 1'b1, 1'b0);
        cycle(8'h04, 8'h00, 1'b1, 1'b0);
        cycle(8'h04, 8'h00, 1'b1, 1'b0);
        cycle(8'h04, 8'h04, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Fairness: everyone requesting, one word each.
        repeat (12) cycle(8'hFF, 8'hFF, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Burst cap between requesters 0 and 7.
        repeat (14) cycle(8'h81, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Stall mid-burst on owner 5.
        repeat (3) cycle(8'h20, 8'h00, 1'b1, 1'b0);
        repeat (10) cycle(8'h20, 8'h00, 1'b0, 1'b0);
        repeat (4) cycle(8'h20, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Abandon: owner 3 drops with requester 6 waiting.
        repeat (3) cycle(8'h08, 8'h00, 1'b1, 1'b0);
        repeat (3) cycle(8'h40, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of owner 4's burst, then 0 wins over 4.
        repeat (3) cycle(8'h10, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(8'h11, 8'h00, 1'b1, 1'b1);
        repeat (4) cycle(8'h11, 8'h00, 1'b1, 1'b0);
        repeat (2) cycle(8'h00, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with sticky requests and occasional resets.
        r = 8'h00;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            l  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rd = ($urandom_range(0, 3) != 0);
            cycle(r, l, rd, ($urandom_range(0, 199) == 0));
        end
        cycle(8'h00, 8'h00, 1'b0, 1'b0);

        for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clock);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_8.md
Name: bus_arbiter_8

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit, 8-source tristate bus.
- Owns the bus mux's 3-bit select. Grants the bus to one of eight requesters, holds ownership for a burst, and re-arbitrates back-to-back with no idle cycle.
- Sits between the requesting units (memory port, I/O, coprocessors) and the single bus sink.

Parameters:
- MAX_BEATS, 16: maximum accepted words per grant before forced release. Legal range 1..256.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  per-requester bus request; bit i held high while requester i has data.
- last  input  8  per-requester final-word flag; only the owner's bit is sampled.
- ready  input  1  sink accepts the current bus word this cycle.
- sel  output  3  registered mux select; binary index of the current or most recent owner.
- grant  output  8  registered one-hot owner indication; all zero when idle.
- bus_valid  output  1  combinational: state==BUSY and req[sel].
- xfer  output  1  combinational: bus_valid and ready (a word is accepted this cycle).

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, grant=0, sel=0, ptr=0, beat_cnt=0.
  - bus_valid=0, xfer=0.
- Clock and reset are named clock/reset. Reset is asynchronous and active-high.
- Internal state:
  - ptr, 3 bits: highest-priority index.
  - beat_cnt, 8 bits: accepted words in the current grant.
  - state: IDLE or BUSY.
- Pick function: first i scanning ptr, ptr+1, …, ptr+7 (mod 8) with req[i]=1.
- IDLE:
  - If req != 0: at the next edge, owner = pick(req), grant = onehot(owner), sel = owner, beat_cnt=0, state=BUSY.
  - Latency from req high to grant high is 1 cycle.
  - If req == 0: stay IDLE. sel holds its previous value (the mux always drives a defined source; grant stays 0).
- BUSY, owner o = sel:
  - Release when any of the following holds:
    - (a) xfer and last[o];
    - (b) xfer and beat_cnt == MAX_BEATS-1;
    - (c) req[o]==0 (abandon; no word counted).
  - No release and xfer: beat_cnt increments.
  - No release and not xfer: everything holds. A stall on ready never causes release.
  - On release edge:
    - ptr = o+1 (mod 8).
    - Remaining requests are evaluated with ptr'=o+1 on the same cycle's req, including req[o] if still high, which is therefore lowest priority.
    - If any: grant the new owner at this same edge, beat_cnt=0, stay BUSY (zero-bubble handoff).
    - Else: grant=0, state=IDLE, sel keeps o.
- MAX_BEATS=1: every accepted word forces release.
- Beat counter never exceeds MAX_BEATS-1; the 8-bit counter covers MAX_BEATS up to 256 without wrap.
- last[] and req[] bits of non-owners are ignored in BUSY except at release.
- A requester dropping and re-raising req in the same cycle as its own release is arbitrated normally at the next release/IDLE evaluation.
- Reset asserted mid-burst: outputs clear immediately (asynchronously). The in-flight word is not accepted. After deassertion, arbitration restarts with ptr=0.
- Invariants:
  - grant is zero or one-hot.
  - When grant != 0, grant == onehot(sel).
  - xfer implies bus_valid.

Test Plan:
- Reset then req=8'b0000_0100: cycle 1 grant=8'h04, sel=2, bus_valid=1. With ready=1 and last[2] on the 3rd word: 3 xfers, then grant=0 and IDLE. Next priority is ptr=3.
- Fairness: req=8'hFF held, last=8'hFF, ready=1 → grants rotate 0,1,2,…,7,0 with one word each. No idle cycle between grants; xfer high every cycle.
- Burst cap: MAX_BEATS=4, req=8'h01 and 8'h80, last=0, ready=1 → owner 0 gets exactly 4 xfers, then owner 7 gets 4, then owner 0 again.
- Stall: owner 5 mid-burst, ready=0 for 10 cycles → grant=8'h20 and beat_cnt unchanged throughout. The count resumes when ready returns, and release still occurs at the MAX_BEATS-th accepted word.
- Abandon: owner 3 drops req with beat_cnt=2 while req[6]=1 → next edge grant=8'h40, sel=6. No xfer is counted in the abandon cycle.
- Async reset asserted mid-cycle during owner 4's burst → grant=0, bus_valid=0, sel=0 before the next clock edge. After release with req=8'h11, owner 0 is granted first.
